// File: rtl/lab_nios_system_pio_pkg.sv
// rtl/lab_nios_system_pio_pkg.sv - shared PIO register offsets and servicer state encoding
package lab_nios_system_pio_pkg;

    // PIO register word offsets as seen on the Avalon-MM slave port.
    localparam logic [1:0] PIO_ADDR_DATA     = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE_CAP = 2'd3;

    // Saturation ceiling of the accepted-event counter.
    localparam logic [15:0] EVT_COUNT_MAX = 16'hFFFF;

    // Servicer sequencing states. RD_LVL and LVL_WAIT are only reachable
    // when the level-read option is built in.
    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RD_CAP   = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_CLR      = 3'd4,
        ST_RD_LVL   = 3'd5,
        ST_LVL_WAIT = 3'd6,
        ST_EMIT     = 3'd7
    } pio_svc_state_t;

    // True for states that sit idle on the bus (no chipselect, no write).
    function automatic logic is_bus_quiet(input pio_svc_state_t s);
        return (s == ST_IDLE) || (s == ST_EMIT);
    endfunction

endpackage

// File: rtl/lab_nios_system_pio_irq_servicer.sv
// rtl/lab_nios_system_pio_irq_servicer.sv - PIO edge-interrupt servicer; optional level read via PIO_IRQ_SERVICER_LEVEL_READ_EN
module lab_nios_system_pio_irq_servicer
    import lab_nios_system_pio_pkg::*;
#(
    parameter int                    PIO_WIDTH     = 18,
    parameter logic [PIO_WIDTH-1:0]  IRQ_MASK_INIT = 18'h3FFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [1:0]            m_address,
    output logic                  m_chipselect,
    output logic                  m_write_n,
    output logic [31:0]           m_writedata,
    input  logic [31:0]           m_readdata,
    input  logic                  irq_in,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [PIO_WIDTH-1:0]  evt_edges,
    output logic [PIO_WIDTH-1:0]  evt_level,
    output logic [15:0]           evt_count
);

    pio_svc_state_t state;
    pio_svc_state_t state_next;

    logic [PIO_WIDTH-1:0] edges_q;
    logic                 evt_accept;

    // Upper read-data bits beyond the PIO width carry nothing for us.
    wire unused_ok = &{1'b0, m_readdata};

    assign evt_accept = (state == ST_EMIT) && evt_ready;

    // State register; reset always restarts from INIT so the mask is rewritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing of one interrupt service pass.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: begin
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (irq_in) begin
                    state_next = ST_RD_CAP;
                end
            end
            ST_RD_CAP: begin
                state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                state_next = ST_CLR;
            end
            ST_CLR: begin
`ifdef PIO_IRQ_SERVICER_LEVEL_READ_EN
                state_next = ST_RD_LVL;
`else
                state_next = ST_EMIT;
`endif
            end
`ifdef PIO_IRQ_SERVICER_LEVEL_READ_EN
            ST_RD_LVL: begin
                state_next = ST_LVL_WAIT;
            end
            ST_LVL_WAIT: begin
                state_next = ST_EMIT;
            end
`endif
            ST_EMIT: begin
                // evt_ready only steers the transition, never evt_valid itself.
                if (evt_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Avalon master drive decoded from the state; held quiet while reset is
    // asserted so an aborted pass issues no further access.
    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_address    = PIO_ADDR_DATA;
        m_writedata  = 32'd0;
        if (!reset && !is_bus_quiet(state)) begin
            case (state)
                ST_INIT: begin
                    m_chipselect = 1'b1;
                    m_write_n    = 1'b0;
                    m_address    = PIO_ADDR_IRQ_MASK;
                    m_writedata  = 32'(IRQ_MASK_INIT);
                end
                ST_RD_CAP: begin
                    m_chipselect = 1'b1;
                    m_address    = PIO_ADDR_EDGE_CAP;
                end
                ST_RD_WAIT: begin
                    m_address    = PIO_ADDR_EDGE_CAP;
                end
                ST_CLR: begin
                    // Any write to edge_capture clears every captured bit.
                    m_chipselect = 1'b1;
                    m_write_n    = 1'b0;
                    m_address    = PIO_ADDR_EDGE_CAP;
                    m_writedata  = 32'd0;
                end
                ST_RD_LVL: begin
                    m_chipselect = 1'b1;
                    m_address    = PIO_ADDR_DATA;
                end
                ST_LVL_WAIT: begin
                    m_address    = PIO_ADDR_DATA;
                end
                default: begin
                    m_chipselect = 1'b0;
                end
            endcase
        end
    end

    // Capture the edge bits once the registered read data is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            edges_q <= '0;
        end else if (state == ST_RD_WAIT) begin
            edges_q <= m_readdata[PIO_WIDTH-1:0];
        end
    end

`ifdef PIO_IRQ_SERVICER_LEVEL_READ_EN
    logic [PIO_WIDTH-1:0] level_q;

    // Snapshot of the input pins taken after the edges have been cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else if (state == ST_LVL_WAIT) begin
            level_q <= m_readdata[PIO_WIDTH-1:0];
        end
    end

    assign evt_level = level_q;
`else
    assign evt_level = '0;
`endif

    // Accepted-event counter, pinned at its ceiling rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_count <= 16'd0;
        end else if (evt_accept && (evt_count != EVT_COUNT_MAX)) begin
            evt_count <= evt_count + 16'd1;
        end
    end

    assign evt_valid = (state == ST_EMIT);
    assign evt_edges = edges_q;

endmodule

// File: doc/lab_nios_system_pio_irq_servicer.md
LAB_NIOS_SYSTEM_PIO_IRQ_SERVICER -- requirements
Module: lab_nios_system_pio_irq_servicer

Interface
REQ-001 SHALL have parameter PIO_WIDTH, default 18, giving the PIO data, mask and edge-capture width.
REQ-002 SHALL have parameter IRQ_MASK_INIT, default 18'h3FFFF, giving the mask value written to the PIO at start-up.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port m_address, output, 2 bits: PIO register word address.
REQ-006 SHALL have port m_chipselect, output, 1 bit: PIO select.
REQ-007 SHALL have port m_write_n, output, 1 bit: active-low write strobe.
REQ-008 SHALL have port m_writedata, output, 32 bits: write data.
REQ-009 SHALL have port m_readdata, input, 32 bits: registered PIO read data.
REQ-010 SHALL have port irq_in, input, 1 bit: PIO interrupt (edge_capture & irq_mask, ORed).
REQ-011 SHALL have port evt_valid, output, 1 bit: event record valid.
REQ-012 SHALL have port evt_ready, input, 1 bit: consumer accepts the record.
REQ-013 SHALL have port evt_edges, output, PIO_WIDTH bits: captured edge bits.
REQ-014 SHALL have port evt_level, output, PIO_WIDTH bits: input level snapshot.
REQ-015 SHALL have port evt_count, output, 16 bits: saturating count of accepted events.

Function
REQ-016 SHALL act as the Avalon-MM master for the PIO register map: address 0 = data, 2 = irq_mask, 3 = edge_capture (any write clears all bits).
REQ-017 SHALL be implemented as the FSM INIT -> IDLE -> RD_CAP -> RD_WAIT -> CLR -> [RD_LVL -> LVL_WAIT] -> EMIT -> IDLE.
REQ-018 SHALL, in INIT (one cycle, entered only from reset), drive chipselect=1, write_n=0, address=2, writedata=zero-extended IRQ_MASK_INIT.
REQ-019 SHALL remain in IDLE with chipselect=0, write_n=1 while irq_in=0, and move to RD_CAP on the cycle irq_in=1 is sampled.
REQ-020 SHALL, in RD_CAP, drive chipselect=1, write_n=1, address=3 for exactly one cycle.
REQ-021 SHALL register m_readdata[PIO_WIDTH-1:0] into the edges register at the end of RD_WAIT (slave read latency 1), with address held at 3.
REQ-022 SHALL, in CLR, drive chipselect=1, write_n=0, address=3, writedata=0 for one cycle.
REQ-023 SHALL handle RD_LVL and LVL_WAIT as in RD_CAP and RD_WAIT, but with address=0 and the result registered into the level register.
REQ-024 SHALL, in EMIT, assert evt_valid with evt_edges/evt_level held stable until evt_ready=1, then return to IDLE on the next cycle.
REQ-025 SHALL NOT depend on evt_ready combinationally for evt_valid.
REQ-026 SHALL increment evt_count on each EMIT handshake and saturate at 16'hFFFF with no wrap.
REQ-027 SHALL drive chipselect=0 and write_n=1 in IDLE and EMIT.
REQ-028 SHALL NOT start a new bus access while in EMIT.
REQ-029 SHALL leave edges that arrive during EMIT asserting irq_in, and serve them on the next IDLE->RD_CAP pass.
REQ-030 SHALL treat the loss of an edge arriving between RD_WAIT and CLR as an accepted limitation: the PIO clear-all semantics allow no alternative.
REQ-031 SHALL still complete RD_CAP->CLR->EMIT when an edge read returns all zeros; the emitted record has evt_edges=0.

Reset
REQ-032 SHALL, with reset=1 at a clk edge, enter INIT and set m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, evt_valid=0, evt_edges=0, evt_level=0, evt_count=0.
REQ-033 SHALL, on reset mid-transaction (any state), abort at the next edge with no further bus access, discard any pending record, and re-run INIT.

Configuration
REQ-034 SHALL, with PIO_IRQ_SERVICER_LEVEL_READ_EN defined, include RD_LVL and LVL_WAIT, taking 6 cycles from IDLE exit to first evt_valid.
REQ-035 SHALL, without PIO_IRQ_SERVICER_LEVEL_READ_EN, omit both states, tie evt_level to 0, and take 4 cycles from IDLE exit to first evt_valid.

Structure
REQ-036 SHALL take the PIO register offsets (0, 2, 3) and the FSM state encoding from the shared package lab_nios_system_pio_pkg.
REQ-037 SHALL be a single module with no sub-modules; the Avalon master drive is a small combinational decode of the state.

Verification
REQ-038 SHALL cover reset release: first cycle shows a write to address 2 with writedata=0x0003FFFF, then chipselect=0 in IDLE.
REQ-039 SHALL cover servicing: PIO model with edge_capture=0x00005, irq_in=1 -> read address 3, write address 3 with data 0, evt_edges=0x00005, evt_count=1.
REQ-040 SHALL cover back-pressure: evt_ready held 0 for 10 cycles with a new edge 0x00100 arriving -> no bus activity, record stable; after accept, a second record with evt_edges=0x00100.
REQ-041 SHALL cover the level read (macro defined): in_port=0x2A5A5 -> evt_level=0x2A5A5, with evt_valid 6 cycles after irq_in is sampled.
REQ-042 SHALL cover saturation: evt_count preloaded via force to 0xFFFE, three accepts -> 0xFFFF.
REQ-043 SHALL cover reset during CLR -> no write issued after reset, next cycle is INIT, evt_valid=0.
